// File: rtl/carpma_hakemi.sv
// carpma_hakemi: round-robin arbiter that shares one carpma_birimi multiplier
// between two requesters and routes each result back through a tag pipeline.
module carpma_hakemi #(
  parameter int GECIKME = 1,
  parameter int SAYAC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               istek0_gecerli_i,
  output logic               istek0_hazir_o,
  input  logic [1:0]         istek0_kontrol_i,
  input  logic [31:0]        istek0_deger1_i,
  input  logic [31:0]        istek0_deger2_i,
  input  logic               istek1_gecerli_i,
  output logic               istek1_hazir_o,
  input  logic [1:0]         istek1_kontrol_i,
  input  logic [31:0]        istek1_deger1_i,
  input  logic [31:0]        istek1_deger2_i,
  output logic               yanit0_gecerli_o,
  input  logic               yanit0_hazir_i,
  output logic               yanit1_gecerli_o,
  input  logic               yanit1_hazir_i,
  output logic [31:0]        yanit_sonuc_o,
  output logic               carp_durdur_o,
  output logic [1:0]         carp_kontrol_o,
  output logic [31:0]        carp_deger1_o,
  output logic [31:0]        carp_deger2_o,
  input  logic [31:0]        carp_sonuc_i,
  output logic               mesgul_o,
  output logic [SAYAC_W-1:0] tamamlanan_o
);

  logic [GECIKME-1:0] etiket_gecerli_q, etiket_gecerli_d;
  logic [GECIKME-1:0] etiket_kimlik_q, etiket_kimlik_d;
  logic               oncelik_q, oncelik_d;
  logic [SAYAC_W-1:0] tamamlanan_q, tamamlanan_d;

  logic kuyruk_gecerli;
  logic kuyruk_kimlik;
  logic kuyruk_hazir;
  logic durdur;
  logic izin0;
  logic izin1;
  logic verildi;

  // The tail entry is time-aligned with carp_sonuc_i, so it names the owner of the current result.
  assign kuyruk_gecerli = etiket_gecerli_q[GECIKME-1];
  assign kuyruk_kimlik  = etiket_kimlik_q[GECIKME-1];
  assign kuyruk_hazir   = kuyruk_kimlik ? yanit1_hazir_i : yanit0_hazir_i;
  assign durdur         = kuyruk_gecerli & ~kuyruk_hazir;

  // Grants are suppressed during a stall and while reset is held, so no handshake leaks out.
  always_comb begin
    izin0 = 1'b0;
    izin1 = 1'b0;
    if (rst_i && !durdur) begin
      if (istek0_gecerli_i && istek1_gecerli_i) begin
        izin0 = ~oncelik_q;
        izin1 = oncelik_q;
      end else begin
        izin0 = istek0_gecerli_i;
        izin1 = istek1_gecerli_i;
      end
    end
  end

  assign verildi = izin0 | izin1;

  always_comb begin
    carp_kontrol_o = 2'b00;
    carp_deger1_o  = 32'd0;
    carp_deger2_o  = 32'd0;
    if (izin0) begin
      carp_kontrol_o = istek0_kontrol_i;
      carp_deger1_o  = istek0_deger1_i;
      carp_deger2_o  = istek0_deger2_i;
    end else if (izin1) begin
      carp_kontrol_o = istek1_kontrol_i;
      carp_deger1_o  = istek1_deger1_i;
      carp_deger2_o  = istek1_deger2_i;
    end
  end

  always_comb begin
    etiket_gecerli_d = etiket_gecerli_q;
    etiket_kimlik_d  = etiket_kimlik_q;
    oncelik_d        = oncelik_q;
    tamamlanan_d     = tamamlanan_q;
    if (!durdur) begin
      for (int i = GECIKME - 1; i > 0; i--) begin
        etiket_gecerli_d[i] = etiket_gecerli_q[i-1];
        etiket_kimlik_d[i]  = etiket_kimlik_q[i-1];
      end
      etiket_gecerli_d[0] = verildi;
      etiket_kimlik_d[0]  = izin1;
      if (verildi) begin
        oncelik_d = ~izin1;
      end
      if (kuyruk_gecerli) begin
        tamamlanan_d = tamamlanan_q + SAYAC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      etiket_gecerli_q <= '0;
      etiket_kimlik_q  <= '0;
      oncelik_q        <= 1'b0;
      tamamlanan_q     <= '0;
    end else begin
      etiket_gecerli_q <= etiket_gecerli_d;
      etiket_kimlik_q  <= etiket_kimlik_d;
      oncelik_q        <= oncelik_d;
      tamamlanan_q     <= tamamlanan_d;
    end
  end

  assign istek0_hazir_o   = izin0;
  assign istek1_hazir_o   = izin1;
  assign yanit0_gecerli_o = kuyruk_gecerli & ~kuyruk_kimlik;
  assign yanit1_gecerli_o = kuyruk_gecerli & kuyruk_kimlik;
  assign yanit_sonuc_o    = carp_sonuc_i;
  assign carp_durdur_o    = durdur;
  assign mesgul_o         = |etiket_gecerli_q;
  assign tamamlanan_o     = tamamlanan_q;

endmodule

// File: tb/tb_carpma_hakemi.sv
// Bench for carpma_hakemi: behavioural multiplier, directed stimulus and a
// scoreboard queue drained by an independent response monitor.
module tb_carpma_hakemi;

  localparam int GEC = 1;
  localparam int SW  = 4;

  localparam logic [1:0] CARPMA_MUL    = 2'b00;
  localparam logic [1:0] CARPMA_MULH   = 2'b01;
  localparam logic [1:0] CARPMA_MULHSU = 2'b10;
  localparam logic [1:0] CARPMA_MULHU  = 2'b11;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          istek0_gecerli_i = 1'b0, istek1_gecerli_i = 1'b0;
  logic          istek0_hazir_o, istek1_hazir_o;
  logic [1:0]    istek0_kontrol_i = '0, istek1_kontrol_i = '0;
  logic [31:0]   istek0_deger1_i = '0, istek0_deger2_i = '0;
  logic [31:0]   istek1_deger1_i = '0, istek1_deger2_i = '0;
  logic          yanit0_gecerli_o, yanit1_gecerli_o;
  logic          yanit0_hazir_i = 1'b1, yanit1_hazir_i = 1'b1;
  logic [31:0]   yanit_sonuc_o;
  logic          carp_durdur_o;
  logic [1:0]    carp_kontrol_o;
  logic [31:0]   carp_deger1_o, carp_deger2_o, carp_sonuc_i;
  logic          mesgul_o;
  logic [SW-1:0] tamamlanan_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        kimlik;
    logic [31:0] deger;
  } beklenen_t;

  beklenen_t sbq[$];

  carpma_hakemi #(.GECIKME(GEC), .SAYAC_W(SW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .istek0_gecerli_i(istek0_gecerli_i), .istek0_hazir_o(istek0_hazir_o),
    .istek0_kontrol_i(istek0_kontrol_i), .istek0_deger1_i(istek0_deger1_i),
    .istek0_deger2_i(istek0_deger2_i),
    .istek1_gecerli_i(istek1_gecerli_i), .istek1_hazir_o(istek1_hazir_o),
    .istek1_kontrol_i(istek1_kontrol_i), .istek1_deger1_i(istek1_deger1_i),
    .istek1_deger2_i(istek1_deger2_i),
    .yanit0_gecerli_o(yanit0_gecerli_o), .yanit0_hazir_i(yanit0_hazir_i),
    .yanit1_gecerli_o(yanit1_gecerli_o), .yanit1_hazir_i(yanit1_hazir_i),
    .yanit_sonuc_o(yanit_sonuc_o), .carp_durdur_o(carp_durdur_o),
    .carp_kontrol_o(carp_kontrol_o), .carp_deger1_o(carp_deger1_o),
    .carp_deger2_o(carp_deger2_o), .carp_sonuc_i(carp_sonuc_i),
    .mesgul_o(mesgul_o), .tamamlanan_o(tamamlanan_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural stand-in for carpma_birimi: GEC-stage pipeline that freezes on durdur.
  function automatic logic [31:0] carp(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (k == CARPMA_MULH || k == CARPMA_MULHSU) ea = {{32{a[31]}}, a};
    if (k == CARPMA_MULH) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (k == CARPMA_MUL) ? p[31:0] : p[63:32];
  endfunction

  logic [31:0] boru [GEC];

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < GEC; i++) boru[i] <= '0;
    end else if (!carp_durdur_o) begin
      boru[0] <= carp(carp_kontrol_o, carp_deger1_o, carp_deger2_o);
      for (int i = 1; i < GEC; i++) boru[i] <= boru[i-1];
    end
  end

  assign carp_sonuc_i = boru[GEC-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic deliver(input logic port);
    beklenen_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_unexpected port=%0d actual=%h expected=none", port, yanit_sonuc_o);
    end else begin
      e = sbq.pop_front();
      checkOutput("sb_port", 32'(port), 32'(e.kimlik));
      checkOutput("sb_sonuc", yanit_sonuc_o, e.deger);
    end
  endtask

  // Response monitor: every completed result handshake must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (yanit0_gecerli_o && yanit1_gecerli_o)
        checkOutput("both_gecerli", 32'd1, 32'd0);
      if (yanit0_gecerli_o && yanit0_hazir_i) deliver(1'b0);
      if (yanit1_gecerli_o && yanit1_hazir_i) deliver(1'b1);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic push(input logic id, input logic [31:0] v);
    sbq.push_back('{kimlik: id, deger: v});
  endtask

  task automatic applyStimulus(input int port, input logic v, input logic [1:0] k,
                               input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      istek0_gecerli_i = v; istek0_kontrol_i = k; istek0_deger1_i = a; istek0_deger2_i = b;
    end else begin
      istek1_gecerli_i = v; istek1_kontrol_i = k; istek1_deger1_i = a; istek1_deger2_i = b;
    end
  endtask

  task automatic idle();
    applyStimulus(0, 1'b0, 2'b00, 32'd0, 32'd0);
    applyStimulus(1, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic doReset();
    rst_i = 1'b0;
    idle();
    sbq.delete();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state, with a request pending to show hazir stays low in reset.
    applyStimulus(0, 1'b1, CARPMA_MUL, 32'd3, 32'd4);
    #3;
    checkOutput("rst_hazir0", 32'(istek0_hazir_o), 32'd0);
    checkOutput("rst_mesgul", 32'(mesgul_o), 32'd0);
    checkOutput("rst_tamamlanan", 32'(tamamlanan_o), 32'd0);
    checkOutput("rst_y0g", 32'(yanit0_gecerli_o), 32'd0);
    checkOutput("rst_y1g", 32'(yanit1_gecerli_o), 32'd0);
    checkOutput("rst_durdur", 32'(carp_durdur_o), 32'd0);
    doReset();

    // Single MUL with one-cycle latency.
    applyStimulus(0, 1'b1, CARPMA_MUL, 32'd121, 32'd70);
    sample();
    checkOutput("s_hazir0", 32'(istek0_hazir_o), 32'd1);
    checkOutput("s_hazir1", 32'(istek1_hazir_o), 32'd0);
    checkOutput("s_deger1", carp_deger1_o, 32'd121);
    push(1'b0, 32'd8470);
    tick();
    idle();
    sample();
    checkOutput("s_y0g", 32'(yanit0_gecerli_o), 32'd1);
    checkOutput("s_sonuc", yanit_sonuc_o, 32'd8470);
    tick();
    checkOutput("s_tamamlanan", 32'(tamamlanan_o), 32'd1);
    checkOutput("s_idle_deger1", carp_deger1_o, 32'd0);

    // Contention from reset: grants alternate 0,1,0,1.
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b1, CARPMA_MULH, 32'h0011_0000, 32'h0003_0000);
      applyStimulus(1, 1'b1, CARPMA_MULHU, 32'h0011_0000, 32'hffff_ffff);
      sample();
      checkOutput("c_hazir0", 32'(istek0_hazir_o), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("c_hazir1", 32'(istek1_hazir_o), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) push(1'b0, 32'd51);
      else            push(1'b1, 32'h0010_ffff);
      tick();
    end
    idle();
    tick();
    tick();
    checkOutput("c_tamamlanan", 32'(tamamlanan_o), 32'd4);

    // Back-to-back on port1 with three cycles of response backpressure.
    applyStimulus(1, 1'b1, CARPMA_MUL, 32'd121, 32'hffff_ffff);
    sample();
    checkOutput("b_hazir1_a", 32'(istek1_hazir_o), 32'd1);
    push(1'b1, 32'hffff_ff87);
    tick();
    applyStimulus(1, 1'b1, CARPMA_MUL, 32'hffff_ff87, 32'd0);
    yanit1_hazir_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      checkOutput("b_durdur", 32'(carp_durdur_o), 32'd1);
      checkOutput("b_hazir1", 32'(istek1_hazir_o), 32'd0);
      checkOutput("b_hazir0", 32'(istek0_hazir_o), 32'd0);
      checkOutput("b_y1g", 32'(yanit1_gecerli_o), 32'd1);
      checkOutput("b_sonuc", yanit_sonuc_o, 32'hffff_ff87);
      checkOutput("b_kontrol", 32'(carp_kontrol_o), 32'd0);
      tick();
    end
    yanit1_hazir_i = 1'b1;
    sample();
    checkOutput("b_durdur_rel", 32'(carp_durdur_o), 32'd0);
    checkOutput("b_hazir1_b", 32'(istek1_hazir_o), 32'd1);
    push(1'b1, 32'd0);
    tick();
    idle();
    tick();
    tick();
    checkOutput("b_tamamlanan", 32'(tamamlanan_o), 32'd6);

    // Signed-by-unsigned high product goes only to port0.
    applyStimulus(0, 1'b1, CARPMA_MULHSU, 32'hffff_ffff, 32'h0011_0000);
    sample();
    checkOutput("h_hazir0", 32'(istek0_hazir_o), 32'd1);
    push(1'b0, 32'hffff_ffff);
    tick();
    idle();
    sample();
    checkOutput("h_y0g", 32'(yanit0_gecerli_o), 32'd1);
    checkOutput("h_y1g", 32'(yanit1_gecerli_o), 32'd0);
    tick();
    checkOutput("h_tamamlanan", 32'(tamamlanan_o), 32'd7);

    // Reset while an operation is in flight.
    applyStimulus(0, 1'b1, CARPMA_MUL, 32'd5, 32'd6);
    sample();
    checkOutput("r_hazir0", 32'(istek0_hazir_o), 32'd1);
    push(1'b0, 32'd30);
    tick();
    idle();
    checkOutput("r_mesgul_pre", 32'(mesgul_o), 32'd1);
    rst_i = 1'b0;
    sbq.delete();
    #1;
    checkOutput("r_mesgul", 32'(mesgul_o), 32'd0);
    checkOutput("r_y0g", 32'(yanit0_gecerli_o), 32'd0);
    checkOutput("r_tamamlanan", 32'(tamamlanan_o), 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    sample();
    checkOutput("r_post_y0g", 32'(yanit0_gecerli_o), 32'd0);
    checkOutput("r_post_y1g", 32'(yanit1_gecerli_o), 32'd0);
    tick();
    applyStimulus(0, 1'b1, CARPMA_MUL, 32'd7, 32'd8);
    applyStimulus(1, 1'b1, CARPMA_MUL, 32'd9, 32'd10);
    sample();
    checkOutput("r_grant0", 32'(istek0_hazir_o), 32'd1);
    checkOutput("r_grant1", 32'(istek1_hazir_o), 32'd0);
    push(1'b0, 32'd56);
    tick();
    idle();
    tick();
    tick();
    checkOutput("r_tamamlanan_post", 32'(tamamlanan_o), 32'd1);

    // Seventeen deliveries wrap the 4-bit counter to 1.
    doReset();
    for (int k = 0; k < 17; k++) begin
      applyStimulus(0, 1'b1, CARPMA_MUL, 32'(k + 1), 32'd3);
      sample();
      checkOutput("w_hazir0", 32'(istek0_hazir_o), 32'd1);
      push(1'b0, 32'((k + 1) * 3));
      tick();
    end
    idle();
    tick();
    tick();
    tick();
    checkOutput("w_tamamlanan", 32'(tamamlanan_o), 32'd1);
    checkOutput("w_mesgul", 32'(mesgul_o), 32'd0);
    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carpma_hakemi.md
Name: carpma_hakemi

Overview:
Round-robin arbiter and sequencer that shares one carpma_birimi multiplier between two requesters, e.g. the core execute stage (port 0) and a coprocessor/accelerator (port 1).
- Accepts MUL/MULH/MULHU/MULHSU requests over valid/ready handshakes.
- Tracks in-flight operations with a tag pipeline and routes each result to its owner.
- Applies response backpressure by driving the multiplier's durdur input.

Parameters:
GECIKME, 1, multiplier latency in cycles from operand presentation to valid sonuc; legal range 1..4.
SAYAC_W, 16, width of the completed-operation counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-low.
istek0_gecerli_i / istek1_gecerli_i  input  1  requester k has an operation pending.
istek0_hazir_o / istek1_hazir_o  output  1  operation of requester k is accepted this cycle.
istek0_kontrol_i / istek1_kontrol_i  input  2  CARPMA_* opcode from tanimlamalar.vh.
istek0_deger1_i / istek1_deger1_i  input  32  operand 1.
istek0_deger2_i / istek1_deger2_i  input  32  operand 2.
yanit0_gecerli_o / yanit1_gecerli_o  output  1  result for requester k is valid.
yanit0_hazir_i / yanit1_hazir_i  input  1  requester k accepts the result.
yanit_sonuc_o  output  32  shared result bus; meaningful only with yanitk_gecerli_o.
carp_durdur_o  output  1  to multiplier durdur_i.
carp_kontrol_o  output  2  to multiplier kontrol_i.
carp_deger1_o / carp_deger2_o  output  32  to multiplier operands.
carp_sonuc_i  input  32  from multiplier sonuc_o.
mesgul_o  output  1  at least one operation is in flight.
tamamlanan_o  output  SAYAC_W  count of delivered results.

Behaviour:
- Reset (rst_i=0, async):
  - Clears tag pipeline valid bits, oncelik=0 and tamamlanan_o=0.
  - All handshake outputs, mesgul_o and carp_durdur_o are forced to 0 while rst_i=0.
  - The multiplier shares rst_i, so any in-flight result is discarded and no yanit is produced after reset release.
- Tag pipeline: GECIKME entries {gecerli, kimlik}.
  - Entry 0 loads {issued, granted id} each non-stalled edge; entries shift toward the tail (index GECIKME-1) on the same edge.
  - The tail is time-aligned with carp_sonuc_i.
- Stall: durdur = tail.gecerli & ~yanit[tail.kimlik]_hazir_i (combinational); carp_durdur_o = durdur.
  - While durdur=1, the multiplier holds sonuc, the tag pipeline holds, and nothing issues.
- Arbitration (combinational, only when durdur=0):
  - Exactly one request valid: grant it.
  - Both valid: grant the requester selected by oncelik.
  - istekk_hazir_o = grant_k & ~durdur. At most one hazir is high per cycle.
- Priority update: on an issue edge, oncelik <= ~granted_id. With no issue, oncelik is unchanged.
- Operand mux: carp_kontrol_o and carp_deger*_o carry the granted requester's inputs; with no grant they are all zero. Operands are passed through unregistered.
- Latency: a request accepted in cycle c gives yanit valid in cycle c+GECIKME if no stall occurs. Throughput is one operation per cycle.
- Response routing:
  - yanitk_gecerli_o = tail.gecerli & (tail.kimlik==k).
  - yanit_sonuc_o = carp_sonuc_i.
  - A result is delivered on the edge where gecerli & hazir; tamamlanan_o increments then and wraps from all-ones to 0.
- mesgul_o = OR of all tag valid bits.
- Simultaneous stall and request: the request waits with hazir=0. The requester must hold its gecerli and operands stable until hazir (the requester's obligation; the arbiter does not latch operands).
- Ordering: results return in issue order; there is no reordering between requesters.

Test Plan:
- Single MUL: port0 requests MUL 121*70 with GECIKME=1, yanit0_hazir_i=1 -> hazir0 in cycle 0; yanit0_gecerli_o=1 with sonuc 8470 in cycle 1; tamamlanan_o=1.
- Contention: both ports valid every cycle; port0 MULH 0x00110000*0x00030000, port1 MULHU 0x00110000*0xffffffff -> grants alternate 0,1,0,1 from reset; responses 51 and 0x0010ffff appear on the matching yanitk_gecerli_o.
- Back-to-back with backpressure: port1 issues MUL 121*-1 then MUL -121*0; yanit1_hazir_i held 0 for 3 cycles -> carp_durdur_o=1 for 3 cycles; sonuc stays 0xffffff87; no hazir is asserted; after release, 0xffffff87 then 0 are delivered in order.
- Signed high product: port0 MULHSU 0xffffffff*0x00110000 -> result 0xffffffff delivered to port0 only; yanit1_gecerli_o stays 0.
- Reset mid-operation: issue on port0, then drive rst_i=0 before the result returns -> mesgul_o=0, yanit*_gecerli_o=0 and tamamlanan_o=0 immediately; no response after release; the next grant goes to port0.
- Counter wrap: SAYAC_W=4 with 17 delivered results -> tamamlanan_o reads 1.
